// File: rtl/rle_tx_packer_if.sv
// Handshake bundle for the RLE transmitter: field input side, flush control
// and the packed 32-bit word output side.
interface rle_tx_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_len;
  logic        flush;
  logic        flush_done;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;

  modport master (
    output in_valid, in_data, in_len, flush, word_ready,
    input  in_ready, flush_done, word_valid, word_data
  );

  modport slave (
    input  in_valid, in_data, in_len, flush, word_ready,
    output in_ready, flush_done, word_valid, word_data
  );
endinterface

// File: rtl/rle_tx_packer.sv
// Run-length encoder packing MSB-first field bits into 32-bit words of eight
// {bit, 3-bit run} nibbles; runs span fields and are closed only by flush.
module rle_tx_packer (
  input  logic              clk,
  input  logic              rst,
  rle_tx_packer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    EMIT,
    FLUSH_RUN,
    FLUSH_PAD,
    FLUSH_EMIT
  } state_t;

  state_t      state;
  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic        run_bit;
  logic [2:0]  run_len;
  logic [3:0]  nib_cnt;
  logic [31:0] acc;
  logic        in_ready_q;
  logic        flush_done_q;
  logic        word_valid_q;
  logic [31:0] word_data_q;

  logic [4:0]  len_c;
  logic        cur_bit;
  logic        last_bit;
  logic        run_extend;
  logic [3:0]  nibble;
  logic [31:0] commit_word;

  // Unfilled slots of acc are always zero, so a commit can simply OR the
  // nibble into its slot.
  always_comb begin
    len_c       = (bus.in_len > 5'd16) ? 5'd16 : bus.in_len;
    cur_bit     = shreg[15];
    last_bit    = (bit_cnt == 5'd1);
    run_extend  = (cur_bit == run_bit) && (run_len != 3'd7);
    nibble      = {run_bit, run_len};
    commit_word = acc | ({nibble, 28'd0} >> {nib_cnt[2:0], 2'b00});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      run_bit      <= 1'b0;
      run_len      <= '0;
      nib_cnt      <= '0;
      acc          <= '0;
      in_ready_q   <= 1'b0;
      flush_done_q <= 1'b0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      flush_done_q <= 1'b0;
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.flush) begin
            state      <= FLUSH_RUN;
            in_ready_q <= 1'b0;
          end else if (bus.in_valid && in_ready_q && (len_c != 5'd0)) begin
            shreg      <= bus.in_data << (5'd16 - len_c);
            bit_cnt    <= len_c;
            state      <= SHIFT;
            in_ready_q <= 1'b0;
          end
        end

        SHIFT: begin
          shreg      <= {shreg[14:0], 1'b0};
          bit_cnt    <= bit_cnt - 5'd1;
          state      <= last_bit ? IDLE : SHIFT;
          in_ready_q <= last_bit;
          if (run_len == 3'd0) begin
            run_bit <= cur_bit;
            run_len <= 3'd1;
          end else if (run_extend) begin
            run_len <= run_len + 3'd1;
          end else begin
            run_bit <= cur_bit;
            run_len <= 3'd1;
            if (nib_cnt == 4'd7) begin
              // Eighth nibble: publish the word on this same edge.
              word_data_q  <= commit_word;
              word_valid_q <= 1'b1;
              acc          <= '0;
              nib_cnt      <= 4'd8;
              state        <= EMIT;
              in_ready_q   <= 1'b0;
            end else begin
              acc     <= commit_word;
              nib_cnt <= nib_cnt + 4'd1;
            end
          end
        end

        EMIT: begin
          if (bus.word_ready) begin
            word_valid_q <= 1'b0;
            nib_cnt      <= '0;
            if (bit_cnt != 5'd0) begin
              state <= SHIFT;
            end else begin
              state      <= IDLE;
              in_ready_q <= 1'b1;
            end
          end
        end

        FLUSH_RUN: begin
          state <= FLUSH_PAD;
          if (run_len != 3'd0) begin
            run_len <= '0;
            run_bit <= 1'b0;
            if (nib_cnt == 4'd7) begin
              word_data_q  <= commit_word;
              word_valid_q <= 1'b1;
              acc          <= '0;
              nib_cnt      <= 4'd8;
              state        <= FLUSH_EMIT;
            end else begin
              acc     <= commit_word;
              nib_cnt <= nib_cnt + 4'd1;
            end
          end
        end

        FLUSH_PAD: begin
          if (nib_cnt != 4'd0) begin
            word_data_q  <= acc;
            word_valid_q <= 1'b1;
            acc          <= '0;
            state        <= FLUSH_EMIT;
          end else begin
            flush_done_q <= 1'b1;
            in_ready_q   <= 1'b1;
            state        <= IDLE;
          end
        end

        FLUSH_EMIT: begin
          if (bus.word_ready) begin
            word_valid_q <= 1'b0;
            nib_cnt      <= '0;
            flush_done_q <= 1'b1;
            in_ready_q   <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.flush_done = flush_done_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;

endmodule

// File: tb/tb_rle_tx_packer.sv
// Directed bench for rle_tx_packer: table of field/flush vectors with
// hand-computed words and flush latencies, plus stall and reset sequences.
module tb_rle_tx_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rle_tx_packer_if bus ();

  rle_tx_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] got[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready) got.push_back(bus.word_data);
    if (bus.flush_done) done_cnt++;
  end

  typedef struct {
    logic [15:0] d0;
    logic [4:0]  l0;
    logic [15:0] d1;
    logic [4:0]  l1;
    int          nf;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 200 && !bus.in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_ready_wait"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic send_field(input logic [15:0] d, input logic [4:0] l, input string name);
    wait_ready(name);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = l;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush(input int exp_lat, input string name);
    int lat;
    int d0;
    wait_ready(name);
    d0 = done_cnt;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    lat = 0;
    while (!bus.flush_done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_flush_lat"}, lat, exp_lat);
    chk({name, "_ready_at_done"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    chk({name, "_done_pulse_width"}, {31'd0, bus.flush_done}, 32'd0);
    chk({name, "_done_count"}, done_cnt - d0, 32'd1);
  endtask

  task automatic wait_word(input string name);
    for (int i = 0; i < 100 && !bus.word_valid; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_word_wait"}, {31'd0, bus.word_valid}, 32'd1);
  endtask

  initial begin
    int base;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_len     = '0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b1;

    //          d0        l0     d1       l1    nf nw  w0            w1            lat
    vecs[0] = '{16'h0006, 5'd6,  16'h0,   5'd0, 1, 1, 32'h3A100000, 32'h0,        3};
    vecs[1] = '{16'h0000, 5'd16, 16'h0,   5'd0, 1, 1, 32'h77200000, 32'h0,        3};
    vecs[2] = '{16'h000F, 5'd4,  16'h000F,5'd4, 2, 1, 32'hF9000000, 32'h0,        3};
    vecs[3] = '{16'hFFFF, 5'd16, 16'h0,   5'd0, 1, 1, 32'hFFA00000, 32'h0,        3};
    vecs[4] = '{16'h000F, 5'd20, 16'h0,   5'd0, 1, 1, 32'h75C00000, 32'h0,        3};
    vecs[5] = '{16'h1234, 5'd0,  16'h0,   5'd0, 1, 0, 32'h0,        32'h0,        2};
    vecs[6] = '{16'h0001, 5'd1,  16'h0,   5'd0, 1, 1, 32'h90000000, 32'h0,        3};
    vecs[7] = '{16'h0005, 5'd3,  16'h0002,5'd2, 2, 1, 32'h91A10000, 32'h0,        3};
    vecs[8] = '{16'h5555, 5'd9,  16'h0,   5'd0, 1, 2, 32'h91919191, 32'h90000000, 3};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",   {31'd0, bus.in_ready},   32'd0);
    chk("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_flush_done", {31'd0, bus.flush_done}, 32'd0);
    chk("rst_word_data",  bus.word_data,           32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Empty flush right after reset
    base = got.size();
    do_flush(2, "empty_flush");
    chk("empty_flush_words", got.size() - base, 32'd0);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      base = got.size();
      send_field(vecs[i].d0, vecs[i].l0, nm);
      if (vecs[i].nf > 1) send_field(vecs[i].d1, vecs[i].l1, nm);
      do_flush(vecs[i].lat, nm);
      chk({nm, "_word_count"}, got.size() - base, vecs[i].nw);
      if (vecs[i].nw > 0 && got.size() > base)
        chk({nm, "_word0"}, got[base], vecs[i].w0);
      if (vecs[i].nw > 1 && got.size() > base + 1)
        chk({nm, "_word1"}, got[base + 1], vecs[i].w1);
    end

    // Backpressure: first word held for 5 cycles with in_ready low
    base = got.size();
    bus.word_ready = 1'b0;
    send_field(16'hAAAA, 5'd16, "bp");
    wait_word("bp");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_data_%0d", i),  bus.word_data,           32'h91919191);
      chk($sformatf("bp_hold_valid_%0d", i), {31'd0, bus.word_valid}, 32'd1);
      chk($sformatf("bp_hold_ready_%0d", i), {31'd0, bus.in_ready},   32'd0);
      @(posedge clk); #1;
    end
    bus.word_ready = 1'b1;
    do_flush(2, "bp");
    chk("bp_word_count", got.size() - base, 32'd2);
    if (got.size() > base)     chk("bp_word0", got[base],     32'h91919191);
    if (got.size() > base + 1) chk("bp_word1", got[base + 1], 32'h91919191);

    // Reset during SHIFT of 16'hFFFF
    base = got.size();
    send_field(16'hFFFF, 5'd16, "rst_shift");
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("rst_shift_in_ready",   {31'd0, bus.in_ready},   32'd0);
    chk("rst_shift_word_valid", {31'd0, bus.word_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_flush(2, "rst_shift");
    chk("rst_shift_words", got.size() - base, 32'd0);

    // Reset while a word is stalled in EMIT
    bus.word_ready = 1'b0;
    send_field(16'hAAAA, 5'd16, "rst_emit");
    wait_word("rst_emit");
    #2 rst = 1'b1;
    #1;
    chk("rst_emit_word_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_emit_word_data",  bus.word_data,           32'd0);
    chk("rst_emit_in_ready",   {31'd0, bus.in_ready},   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.word_ready = 1'b1;
    base = got.size();
    do_flush(2, "rst_emit");
    chk("rst_emit_words", got.size() - base, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rle_tx_packer.md
# rle_tx_packer

Run-length encoding transmitter for the ODE-solver host IO link. The block takes variable-width result fields (up to 16 bits, MSB first) from the result-readout path and packs them into 32-bit words in the IO word format. Each word carries eight 4-bit nibbles, each {bit value, 3-bit run length}. It sits between the RAM readout sequencer and the shared 32-bit IO data bus, and it mirrors the IO receiver's decoder exactly.

## Interface
- No parameters. Word width is 32, nibble count is 8, and maximum run is 7, all fixed by the IO format.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  a field is offered.
- in_ready  out  1  the block can accept a field.
- in_data  in  16  field bits, right-aligned; bit in_len-1 is sent first.
- in_len  in  5  field width 0..16. A value of 0 adds no bits. Values above 16 are clamped to 16.
- flush  in  1  end of message: close the current run, pad the word, emit it.
- flush_done  out  1  one-cycle pulse when the flush has completed.
- word_valid  out  1  word_data holds a complete word.
- word_ready  in  1  the consumer accepts the word.
- word_data  out  32  packed word. Nibble k occupies [31-4k:28-4k]: bit 31-4k is the value and [30-4k:28-4k] is the run length.

## Operation
- Reset values: in_ready=0 while rst is high, flush_done=0, word_valid=0, word_data=0.
- Reset clears the internal state: FSM=IDLE, run_len=0, run_bit=0, nib_cnt=0, field shift register and bit counter cleared.
- FSM states are IDLE, SHIFT, EMIT, FLUSH_RUN, FLUSH_PAD and FLUSH_EMIT.
- IDLE
  - in_ready=1 only in IDLE.
  - If flush=1, go to FLUSH_RUN. Flush has priority over in_valid; no field is accepted that cycle.
  - Else if in_valid=1, latch in_data and the clamped in_len, then go to SHIFT (or stay in IDLE if the length is 0).
- SHIFT: consume one bit b per cycle, MSB first.
  - If run_len=0, set run_bit=b and run_len=1.
  - If b=run_bit and run_len<7, increment run_len.
  - Otherwise commit nibble {run_bit, run_len} into slot nib_cnt, increment nib_cnt, and restart the run with run_bit=b, run_len=1.
- Word fill: if a commit makes nib_cnt=8, the word is loaded into word_data with word_valid=1 on that edge, and the FSM goes to EMIT.
- End of field: after the last bit of a field, return to IDLE. Runs continue across field boundaries; only flush terminates a run.
- EMIT
  - Holds word_data stable and word_valid=1 until word_valid&word_ready.
  - On acceptance: word_valid=0, nib_cnt=0, then return to SHIFT if field bits remain, else IDLE.
  - No bits are consumed in EMIT.
- FLUSH_RUN: if run_len>0, commit the run as in SHIFT and clear run_len. If that commit fills the word, go to FLUSH_EMIT; otherwise go to FLUSH_PAD.
- FLUSH_PAD
  - If nib_cnt>0, fill the remaining slots with 4'b0000 (zero-length runs are ignored by the decoder), load word_data, set word_valid, and go to FLUSH_EMIT.
  - If nib_cnt=0, pulse flush_done and go to IDLE.
- FLUSH_EMIT: wait for acceptance as in EMIT, then pulse flush_done for one cycle, clear nib_cnt, and go to IDLE.
- Arithmetic: run_len is 3 bits and never wraps, because commit is forced at 7. nib_cnt is 4 bits, 0..8.
- Unused word slots never carry stale nibbles; they are zeroed when nib_cnt returns to 0.
- flush and in_valid are ignored outside IDLE.

## Timing
- Field accepted on edge k: its bits are consumed on edges k+1..k+len if no word stall occurs. in_ready is high again after edge k+len, so back-to-back fields cost len+1 cycles.
- Word stall: each EMIT adds at least 1 cycle, extended by however long word_ready stays low.
- Word latency: word_valid rises on the same edge as the commit of the 8th nibble. Acceptance is on any edge where word_valid&word_ready.
- Flush latency, with no stall and word_ready=1:
  - Pending nibbles: flush_done pulses 3 cycles after flush is sampled in IDLE.
  - Nothing pending: it pulses 2 cycles after.
- Reset mid-operation: outputs take their reset values immediately (asynchronously). Any partial word and any partial field are discarded.
- word_ready high with word_valid low has no effect.

## Test plan
- n field: n field 6'b000110 (in_len=6), then flush with word_ready=1 -> word 0x3A100000, then flush_done.
- Long run: 16'h0000 (in_len=16) then flush -> word 0x77200000 (runs of 7, 7 and 2).
- Cross-field run: 4'b1111 twice, then flush -> single word 0xF9000000; the run continues across the field boundary.
- Backpressure: 16'hAAAA with word_ready=0 for 5 cycles after the first word_valid.
  - First word 0x91919191 is held stable for all 5 cycles, and in_ready stays 0.
  - After release, flush yields a second 0x91919191, then flush_done.
- Empty flush: flush right after reset -> no word_valid, and flush_done pulses 2 cycles later.
- Reset mid-stream: assert rst during SHIFT of 16'hFFFF.
  - word_valid and in_ready drop immediately.
  - After release, flush gives flush_done with no word.
